// File: rtl/stepper_pkg.sv
// Shared encodings for the stepper sequencer: drive modes, FSM states,
// the eight-entry coil phase table and index helpers.
package stepper_pkg;

  localparam logic [1:0] MODE_WAVE = 2'b00;
  localparam logic [1:0] MODE_FULL = 2'b01;
  localparam logic [1:0] MODE_HALF = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Element [i] is the coil pattern for phase index i (index 0 is the rightmost)
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  // The reserved encoding 11 behaves as wave drive
  function automatic logic [1:0] normalise_mode(input logic [1:0] mode);
    case (mode)
      MODE_FULL: normalise_mode = MODE_FULL;
      MODE_HALF: normalise_mode = MODE_HALF;
      default:   normalise_mode = MODE_WAVE;
    endcase
  endfunction

  function automatic logic [2:0] align_index(input logic [1:0] mode, input logic [2:0] index);
    case (mode)
      MODE_FULL: align_index = {index[2:1], 1'b1};
      MODE_HALF: align_index = index;
      default:   align_index = {index[2:1], 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/stepper_sequencer_if.sv
// Command/status bundle between the command decoder (master) and the
// stepper sequencer (slave).
interface stepper_sequencer_if #(
  parameter int DIV_WIDTH = 24,
  parameter int POS_WIDTH = 16
);
  logic                 enable;
  logic [1:0]           mode;
  logic                 direccion;
  logic [DIV_WIDTH-1:0] period;
  logic                 start;
  logic [POS_WIDTH-1:0] steps_req;
  logic                 stop;
  logic [3:0]           senial_motor;
  logic                 busy;
  logic                 done;
  logic [POS_WIDTH-1:0] position;

  modport master (
    output enable, mode, direccion, period, start, steps_req, stop,
    input  senial_motor, busy, done, position
  );

  modport slave (
    input  enable, mode, direccion, period, start, steps_req, stop,
    output senial_motor, busy, done, position
  );
endinterface

// File: rtl/step_rate_divider.sv
// Step-rate counter: emits a one-cycle step_tick every `period` cycles and
// freezes while period is zero.
module step_rate_divider #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 step_tick
);

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] count_r;

  // >= so that shrinking period below the current count fires immediately
  assign step_tick = !clear && (period != DIV_ZERO) && (count_r >= (period - DIV_ONE));

  // Cycle counter between steps
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count_r <= DIV_ZERO;
    end else if (clear) begin
      count_r <= DIV_ZERO;
    end else if (period == DIV_ZERO) begin
      count_r <= count_r;
    end else if (step_tick) begin
      count_r <= DIV_ZERO;
    end else begin
      count_r <= count_r + DIV_ONE;
    end
  end

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper-motor phase sequencer: wave/full/half drive, bounded or continuous
// moves, signed position tracking and registered coil outputs.
module stepper_sequencer
  import stepper_pkg::*;
#(
  parameter int DIV_WIDTH = 24,
  parameter int POS_WIDTH = 16
) (
  input  logic              clock,
  input  logic              rst,
  stepper_sequencer_if.slave bus
);

  localparam logic [POS_WIDTH-1:0] POS_ZERO = {POS_WIDTH{1'b0}};
  localparam logic [POS_WIDTH-1:0] POS_ONE  = {{(POS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};

  state_t               state_r;
  logic [2:0]           index_r;
  logic [1:0]           mode_r;
  logic [POS_WIDTH-1:0] remaining_r;
  logic [POS_WIDTH-1:0] position_r;
  logic [3:0]           senial_r;
  logic                 busy_r;
  logic                 done_r;

  logic       step_tick_s;
  logic       abort_s;
  logic       start_ok_s;
  logic       clear_s;
  logic [2:0] step_size_s;
  logic [2:0] next_index_s;

  assign abort_s      = bus.stop || !bus.enable;
  assign start_ok_s   = bus.start && bus.enable && (bus.period != DIV_ZERO) && !bus.stop;
  assign clear_s      = (state_r != ST_RUN) || abort_s;
  assign step_size_s  = (mode_r == MODE_HALF) ? 3'd1 : 3'd2;
  assign next_index_s = bus.direccion ? (index_r - step_size_s) : (index_r + step_size_s);

  step_rate_divider #(.DIV_WIDTH(DIV_WIDTH)) u_rate (
    .clock     (clock),
    .rst       (rst),
    .clear     (clear_s),
    .period    (bus.period),
    .step_tick (step_tick_s)
  );

  // Move FSM with registered coil drive, status and position
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      index_r     <= 3'd0;
      mode_r      <= MODE_WAVE;
      remaining_r <= POS_ZERO;
      position_r  <= POS_ZERO;
      senial_r    <= 4'b0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      senial_r <= bus.enable ? PHASE_TABLE[index_r] : 4'b0000;
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_ok_s) begin
            state_r     <= ST_RUN;
            mode_r      <= normalise_mode(bus.mode);
            index_r     <= align_index(normalise_mode(bus.mode), index_r);
            remaining_r <= bus.steps_req;
            busy_r      <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          // An abort beats a step that would fire on the same edge
          if (abort_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (step_tick_s) begin
            index_r    <= next_index_s;
            position_r <= bus.direccion ? (position_r - POS_ONE) : (position_r + POS_ONE);
            if (remaining_r != POS_ZERO) begin
              remaining_r <= remaining_r - POS_ONE;
              if (remaining_r == POS_ONE) begin
                state_r <= ST_DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                state_r <= ST_RUN;
              end
            end else begin
              remaining_r <= POS_ZERO;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.senial_motor = senial_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.position     = position_r;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Directed bench for stepper_sequencer: timing of steps, mode alignment,
// done pulse, stop/enable aborts, live period changes and async reset.
module tb_stepper_sequencer;

  logic clock;
  logic rst;
  int   checks;
  int   failures;

  logic [3:0] half_seq [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                               4'b0010, 4'b0011, 4'b0001, 4'b1001};
  logic [3:0] full_rev [4] = '{4'b1001, 4'b0011, 4'b0110, 4'b1100};

  stepper_sequencer_if #(.DIV_WIDTH(24), .POS_WIDTH(16)) bus ();

  stepper_sequencer #(.DIV_WIDTH(24), .POS_WIDTH(16)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.mode = 2'b00;
    bus.direccion = 1'b0;
    bus.period = 24'd0;
    bus.start = 1'b0;
    bus.steps_req = 16'd0;
    bus.stop = 1'b0;
    cyc(2);
    check_val("rst_pat", 32'(bus.senial_motor), 32'h0);
    check_val("rst_busy", 32'(bus.busy), 32'h0);
    check_val("rst_done", 32'(bus.done), 32'h0);
    check_val("rst_pos", 32'(bus.position), 32'h0);
    rst = 1'b0;
    cyc(1);

    // Half-step forward, 8 steps, period 4
    bus.enable = 1'b1;
    bus.mode = 2'b10;
    bus.direccion = 1'b0;
    bus.period = 24'd4;
    bus.steps_req = 16'd8;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check_val("half_busy", 32'(bus.busy), 32'h1);
    cyc(1);
    check_val("half_first", 32'(bus.senial_motor), 32'h8);
    for (int k = 1; k <= 8; k++) begin
      cyc(3);
      check_val("half_done", 32'(bus.done), 32'(k == 8));
      check_val("half_hold", 32'(bus.senial_motor), 32'(half_seq[k-1]));
      cyc(1);
      check_val("half_pat", 32'(bus.senial_motor), 32'(half_seq[k % 8]));
    end
    check_val("half_done_end", 32'(bus.done), 32'h0);
    check_val("half_busy_end", 32'(bus.busy), 32'h0);
    check_val("half_pos", 32'(bus.position), 32'h8);

    // Asynchronous reset in the middle of a continuous wave move
    bus.mode = 2'b00;
    bus.period = 24'd2;
    bus.steps_req = 16'd0;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(5);
    check_val("mid_busy", 32'(bus.busy), 32'h1);
    check_val("mid_pos", 32'(bus.position), 32'd10);
    #2 rst = 1'b1;
    #1;
    check_val("async_pat", 32'(bus.senial_motor), 32'h0);
    check_val("async_busy", 32'(bus.busy), 32'h0);
    check_val("async_pos", 32'(bus.position), 32'h0);
    cyc(1);
    rst = 1'b0;

    // Full-step reverse, 4 steps, period 3, from index 0
    bus.mode = 2'b01;
    bus.direccion = 1'b1;
    bus.period = 24'd3;
    bus.steps_req = 16'd4;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(1);
    check_val("full_align", 32'(bus.senial_motor), 32'hC);
    for (int k = 1; k <= 4; k++) begin
      cyc(2);
      check_val("full_done", 32'(bus.done), 32'(k == 4));
      cyc(1);
      check_val("full_pat", 32'(bus.senial_motor), 32'(full_rev[k-1]));
    end
    check_val("full_pos", 32'(bus.position), 32'h0000FFFC);
    check_val("full_busy_end", 32'(bus.busy), 32'h0);

    // Continuous wave, stop after 5 steps with a step pending on the stop edge
    pulse_reset();
    bus.mode = 2'b00;
    bus.direccion = 1'b0;
    bus.period = 24'd2;
    bus.steps_req = 16'd0;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(11);
    check_val("wave_busy", 32'(bus.busy), 32'h1);
    check_val("wave_pos5", 32'(bus.position), 32'd5);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    check_val("stop_busy", 32'(bus.busy), 32'h0);
    check_val("stop_done", 32'(bus.done), 32'h0);
    check_val("stop_pos", 32'(bus.position), 32'd5);
    cyc(3);
    check_val("stop_hold", 32'(bus.senial_motor), 32'h4);
    check_val("stop_no_done", 32'(bus.done), 32'h0);

    // Live period change 10 -> 2 at count 7, then freeze with period 0
    pulse_reset();
    bus.mode = 2'b10;
    bus.period = 24'd10;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(7);
    check_val("per_pos0", 32'(bus.position), 32'h0);
    bus.period = 24'd2;
    cyc(1);
    check_val("per_pos1", 32'(bus.position), 32'h1);
    check_val("per_pat_lag", 32'(bus.senial_motor), 32'h8);
    cyc(1);
    check_val("per_pat1", 32'(bus.senial_motor), 32'hC);
    cyc(1);
    check_val("per_pos2", 32'(bus.position), 32'h2);
    cyc(1);
    check_val("per_pat2", 32'(bus.senial_motor), 32'h4);
    cyc(2);
    check_val("per_pat3", 32'(bus.senial_motor), 32'h6);
    check_val("per_pos3", 32'(bus.position), 32'h3);
    bus.period = 24'd0;
    cyc(5);
    check_val("frz_pos", 32'(bus.position), 32'h3);
    check_val("frz_busy", 32'(bus.busy), 32'h1);
    check_val("frz_pat", 32'(bus.senial_motor), 32'h6);
    bus.enable = 1'b0;
    cyc(1);
    check_val("en_pat", 32'(bus.senial_motor), 32'h0);
    check_val("en_busy", 32'(bus.busy), 32'h0);
    check_val("en_done", 32'(bus.done), 32'h0);

    // Starts that must be ignored
    bus.enable = 1'b1;
    bus.period = 24'd0;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check_val("ign_per0", 32'(bus.busy), 32'h0);
    cyc(1);
    bus.enable = 1'b0;
    bus.period = 24'd4;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check_val("ign_en0", 32'(bus.busy), 32'h0);
    cyc(1);
    check_val("ign_en0_pat", 32'(bus.senial_motor), 32'h0);
    check_val("ign_en0_busy", 32'(bus.busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stepper_sequencer.md
Name: stepper_sequencer

Overview:
Parametrised stepper-motor phase sequencer for unipolar/bipolar drivers without a driver shield. It supports wave, full-step (two-phase-on) and half-step modes, with a programmable step period in clock cycles. It runs either a bounded move of N steps with a done pulse or continuous rotation, and tracks a signed position. It sits between the command decoder and the four coil outputs.

Parameters:
DIV_WIDTH, 24, width of the step-period counter and `period` input (clock cycles per step)
POS_WIDTH, 16, width of `steps_req`, the remaining-steps counter and `position`

Ports:
clock  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  coil enable; 0 de-energises coils and aborts any move
mode  in  2  00 wave, 01 full, 10 half, 11 treated as wave; sampled only on accepted start
direccion  in  1  0 forward (+), 1 reverse (-); live during a move
period  in  DIV_WIDTH  clock cycles per step; live; 0 pauses stepping
start  in  1  one-cycle request to begin a move
steps_req  in  POS_WIDTH  step count, latched on accepted start; 0 means continuous
stop  in  1  abort request
senial_motor  out  4  registered coil drive pattern
busy  out  1  high while a move is active
done  out  1  one-cycle pulse when a bounded move completes
position  out  POS_WIDTH  two's-complement step position; wraps modulo 2^POS_WIDTH

Behaviour:
- Reset (async, immediate): state IDLE; phase index 0; rate counter 0; remaining 0; position 0; senial_motor 0000; busy 0; done 0.
- Phase table, indexed 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - Wave uses even indices only; full uses odd indices only; half uses all eight.
  - Index step is ±1 in half mode and ±2 otherwise, wrapping mod 8.
- On accepted start, the index is aligned before any step:
  - Wave: clear bit 0.
  - Full: set bit 0.
  - Half: unchanged.
- senial_motor is registered each cycle as `enable ? table[index] : 0000`, so there is 1 cycle of latency after an index change. When IDLE with enable=1, the current pattern is held (holding torque).
- States:
  - IDLE: start & enable & period≠0 & !stop → RUN. This latches mode and steps_req into remaining, clears the rate counter and sets busy=1. Otherwise start is ignored.
  - RUN: the rate counter increments each cycle. A step fires when counter ≥ period-1; the counter then returns to 0. The ≥ covers period being reduced below the current count. On a step: update index, position ±1, and decrement remaining if it is non-zero. If remaining goes 1→0 → DONE.
  - RUN with period=0: counter and index hold, busy stays 1.
  - RUN with stop or !enable: → IDLE, busy=0, no done, and no step taken that cycle (stop wins over a coincident step).
  - DONE: done=1 and busy=0 for exactly one cycle → IDLE.
- start while in RUN or DONE is ignored.
- A continuous move (steps_req=0) never enters DONE.
- Timing: start accepted at cycle t gives busy=1 at t+1. The first step's index update is at t+period; senial_motor changes at t+period+1. Later steps follow every period cycles.
- Position counts steps regardless of mode: a half-step counts 1 and a full step counts 1.

Decomposition:
- Package stepper_pkg holds:
  - mode encodings (MODE_WAVE, MODE_FULL, MODE_HALF)
  - the 8-entry phase table constant
  - FSM state encoding (IDLE, RUN, DONE)
- Sub-module step_rate_divider (DIV_WIDTH): inputs clock, rst, clear, period. Outputs a one-cycle step_tick using the ≥ comparison, and holds its count when period=0.

Test Plan:
- Reset mid-move (assert rst while RUN) → outputs 0000/busy 0/position 0 immediately, without waiting for a clock edge.
- mode=10, direccion=0, period=4, steps_req=8, start → senial_motor cycles through all 8 table entries, one change every 4 clocks, ending on 1000. position=8; a single done pulse arrives 32 cycles after busy rises.
- mode=01, direccion=1, period=3, steps_req=4 from index 0 → patterns 1100 (aligned), then 1001, 0011, 0110, 1100. position=-4 (0xFFFC).
- mode=00, steps_req=0, period=2, then stop after 5 steps → busy falls the cycle after stop. No done pulse; position=5; the final pattern is held.
- Mid-move, change period 10→2 while the counter is at 7 → a step fires on the next cycle, then a step every 2 cycles. Setting period=0 freezes the index with busy=1.
- Drop enable during RUN → senial_motor=0000 the next cycle, busy=0, no done. Start with period=0 or enable=0 → ignored, busy stays 0.
